// File: rtl/upload_loader.sv
// Framed-upload receiver: parses MAGIC / length / address / payload / checksum
// from a toggle-signalled byte stream and emits little-endian packed word writes.
module upload_loader #(
   parameter int          DATA_BYTES = 4,
   parameter int          LEN_BYTES  = 2,
   parameter int          ADDR_BYTES = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter logic [7:0]  MAGIC      = 8'hA5,
   parameter int          ADDR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clk_enable,
   input  logic                    rx_update,
   input  logic [7:0]              rx_byte,
   output logic                    we,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic [8*DATA_BYTES-1:0] wdata,
   output logic [DATA_BYTES-1:0]   wstrb,
   output logic [2:0]              stage,
   output logic                    busy,
   output logic                    complete,
   output logic                    error
);

   localparam int LW     = 8 * LEN_BYTES;
   localparam int LANE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_LEN = 3'd1, S_ADDR = 3'd2, S_DATA = 3'd3,
      S_CSUM = 3'd4, S_DONE = 3'd5, S_ERR = 3'd6
   } state_t;

   state_t                         state;
   logic                           prev_update;
   logic [LW-1:0]                  len_q;      // length while parsing, remaining bytes in DATA
   logic [ADDR_WIDTH-1:0]          addr_q;
   logic [ADDR_WIDTH-1:0]          off_q;      // payload offset of current word's first byte
   logic [2:0]                     fcnt;       // byte count within LEN/ADDR field
   logic [7:0]                     sum;
   logic [LANE_W-1:0]              lane;
   logic [DATA_BYTES-1:0][7:0]     buf_q;
   logic [DATA_BYTES-1:0]          stb_q;

   logic                           evt;
   logic [LW+7:0]                  len_cat;
   logic [LW-1:0]                  len_next;
   logic [ADDR_WIDTH+7:0]          addr_cat;
   logic [ADDR_WIDTH-1:0]          addr_next;
   logic [ADDR_WIDTH-1:0]          base;
   logic                           word_end;
   logic [DATA_BYTES-1:0][7:0]     buf_nxt;
   logic [DATA_BYTES-1:0]          stb_nxt;

   // Byte-event detect, field shifters and the word buffer with the new byte merged in
   always_comb begin
      evt       = clk_enable && (rx_update != prev_update);
      len_cat   = {len_q, rx_byte};
      len_next  = len_cat[LW-1:0];
      addr_cat  = {addr_q, rx_byte};
      addr_next = addr_cat[ADDR_WIDTH-1:0];
      base      = (ADDR_BYTES == 0) ? ADDR_WIDTH'(BASE_ADDR) : addr_q;
      word_end  = (lane == LANE_W'(DATA_BYTES - 1)) || (len_q == LW'(1));
      buf_nxt   = buf_q;
      stb_nxt   = stb_q;
      buf_nxt[lane] = rx_byte;
      stb_nxt[lane] = 1'b1;
   end

   assign stage = state;
   assign busy  = (state == S_LEN) || (state == S_ADDR) || (state == S_DATA) || (state == S_CSUM);

   // Frame parser FSM with registered write port and sticky status
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         prev_update <= rx_update;
         len_q       <= '0;
         addr_q      <= '0;
         off_q       <= '0;
         fcnt        <= '0;
         sum         <= '0;
         lane        <= '0;
         buf_q       <= '0;
         stb_q       <= '0;
         we          <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         wstrb       <= '0;
         complete    <= 1'b0;
         error       <= 1'b0;
      end else if (clk_enable) begin
         prev_update <= rx_update;
         we          <= 1'b0;
         if (evt) begin
            case (state)
               S_IDLE: begin
                  if (rx_byte == MAGIC) begin
                     state  <= S_LEN;
                     sum    <= '0;
                     len_q  <= '0;
                     addr_q <= '0;
                     off_q  <= '0;
                     fcnt   <= '0;
                     lane   <= '0;
                     buf_q  <= '0;
                     stb_q  <= '0;
                  end
               end
               S_LEN: begin
                  sum   <= sum + rx_byte;
                  len_q <= len_next;
                  if (int'(fcnt) == LEN_BYTES - 1) begin
                     fcnt <= '0;
                     if (ADDR_BYTES > 0)      state <= S_ADDR;
                     else if (len_next == '0) state <= S_CSUM;
                     else                     state <= S_DATA;
                  end else begin
                     fcnt <= fcnt + 3'd1;
                  end
               end
               S_ADDR: begin
                  sum    <= sum + rx_byte;
                  addr_q <= addr_next;
                  if (int'(fcnt) == ADDR_BYTES - 1) begin
                     fcnt  <= '0;
                     state <= (len_q == '0) ? S_CSUM : S_DATA;
                  end else begin
                     fcnt <= fcnt + 3'd1;
                  end
               end
               S_DATA: begin
                  sum   <= sum + rx_byte;
                  len_q <= len_q - LW'(1);
                  if (word_end) begin
                     we    <= 1'b1;
                     addr  <= base + off_q;
                     wdata <= buf_nxt;
                     wstrb <= stb_nxt;
                     buf_q <= '0;
                     stb_q <= '0;
                     off_q <= off_q + ADDR_WIDTH'(DATA_BYTES);
                     lane  <= '0;
                  end else begin
                     buf_q <= buf_nxt;
                     stb_q <= stb_nxt;
                     lane  <= lane + 1'b1;
                  end
                  if (len_q == LW'(1)) state <= S_CSUM;
               end
               S_CSUM: begin
                  if (rx_byte == sum) begin
                     state    <= S_DONE;
                     complete <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
